// File: rtl/lbp_core.sv
// Local Binary Pattern engine for a fixed 128x128 8-bit image: a 3x3 window slides
// over interior pixels. Optional macro LBP_BORDER_WRITE_EN adds zero writes for every border pixel.
module lbp_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        gray_ready,
  output logic        gray_req,
  output logic [13:0] gray_addr,
  input  logic [7:0]  gray_data,
  output logic        lbp_valid,
  output logic [13:0] lbp_addr,
  output logic [7:0]  lbp_data,
  output logic        finish,
  output logic [2:0]  dbg_state
);

  // Handshake: gray_req is held for exactly one cycle per read. The data for that read
  // arrives on gray_data at the rising edge that ends the request cycle.
  // lbp_valid is a single-cycle write strobe and is never high together with gray_req.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_CALC   = 3'd2,
    S_BORDER = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [6:0] LAST = 7'd126;

  state_t      state_q, state_d;
  logic [6:0]  row_q, row_d, col_q, col_d;
  logic [3:0]  nxt_q, nxt_d;
  logic [3:0]  cur_q, cur_d;
  logic        gray_req_q, req_d;
  logic [13:0] gray_addr_q, addr_d;
  logic        lbp_valid_q, valid_d;
  logic [13:0] lbp_addr_q, laddr_d;
  logic [7:0]  lbp_data_q, ldata_d;
  logic        fin_q, fin_d;
  logic        shift, issue;
  logic [7:0]  win_q [9];
  logic [7:0]  lbp_calc;

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = fin_q;
  assign dbg_state = state_q;

  // Window slots are column-major: slot = 3*column_offset + row_offset.
  function automatic logic [13:0] pix_addr(input logic [6:0] r, input logic [6:0] c,
                                           input logic [3:0] s);
    logic [1:0] dr, dc;
    logic [6:0] re, ce;
    dr = 2'd0;
    dc = 2'd0;
    case (s)
      4'd0: begin dc = 2'd0; dr = 2'd0; end
      4'd1: begin dc = 2'd0; dr = 2'd1; end
      4'd2: begin dc = 2'd0; dr = 2'd2; end
      4'd3: begin dc = 2'd1; dr = 2'd0; end
      4'd4: begin dc = 2'd1; dr = 2'd1; end
      4'd5: begin dc = 2'd1; dr = 2'd2; end
      4'd6: begin dc = 2'd2; dr = 2'd0; end
      4'd7: begin dc = 2'd2; dr = 2'd1; end
      default: begin dc = 2'd2; dr = 2'd2; end
    endcase
    re = r + {5'd0, dr} - 7'd1;
    ce = c + {5'd0, dc} - 7'd1;
    return {re, ce};
  endfunction

  // Slot 8 (bottom-right) is taken straight from gray_data as it is captured.
  always_comb begin
    logic [7:0] ctr;
    ctr = win_q[4];
    lbp_calc = {gray_data >= ctr, win_q[5] >= ctr, win_q[2] >= ctr, win_q[7] >= ctr,
                win_q[1] >= ctr, win_q[6] >= ctr, win_q[3] >= ctr, win_q[0] >= ctr};
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    nxt_d   = nxt_q;
    cur_d   = cur_q;
    req_d   = 1'b0;
    addr_d  = gray_addr_q;
    valid_d = 1'b0;
    laddr_d = lbp_addr_q;
    ldata_d = lbp_data_q;
    fin_d   = fin_q;
    shift   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        row_d = 7'd1;
        col_d = 7'd1;
        nxt_d = 4'd0;
        if (gray_ready) begin
          state_d = S_FETCH;
          issue   = 1'b1;
        end
      end
      S_FETCH: begin
        if (gray_req_q && cur_q == 4'd8) begin
          state_d = S_CALC;
          valid_d = 1'b1;
          laddr_d = {row_q, col_q};
          ldata_d = lbp_calc;
        end else if (nxt_q != 4'd9 && gray_ready) begin
          issue = 1'b1;
        end
      end
      S_CALC: begin
        if (row_q == LAST && col_q == LAST) begin
`ifdef LBP_BORDER_WRITE_EN
          state_d = S_BORDER;
          row_d   = 7'd0;
          col_d   = 7'd0;
`else
          state_d = S_DONE;
`endif
        end else begin
          // A new row needs a full window; otherwise slide and fetch one column.
          if (col_q == LAST) begin
            row_d = row_q + 7'd1;
            col_d = 7'd1;
            nxt_d = 4'd0;
          end else begin
            col_d = col_q + 7'd1;
            nxt_d = 4'd6;
            shift = 1'b1;
          end
          state_d = S_FETCH;
          issue   = gray_ready;
        end
      end
`ifdef LBP_BORDER_WRITE_EN
      S_BORDER: begin
        valid_d = 1'b1;
        laddr_d = {row_q, col_q};
        ldata_d = 8'd0;
        if (row_q == 7'd127 && col_q == 7'd127) begin
          state_d = S_DONE;
        end else if (row_q == 7'd0 || row_q == 7'd127) begin
          if (col_q == 7'd127) begin
            row_d = row_q + 7'd1;
            col_d = 7'd0;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else if (col_q == 7'd0) begin
          col_d = 7'd127;
        end else begin
          row_d = row_q + 7'd1;
          col_d = 7'd0;
        end
      end
`endif
      S_DONE: fin_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      req_d  = 1'b1;
      addr_d = pix_addr(row_d, col_d, nxt_d);
      cur_d  = nxt_d;
      nxt_d  = nxt_d + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= 7'd0;
      col_q       <= 7'd0;
      nxt_q       <= 4'd0;
      cur_q       <= 4'd0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= 14'd0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= 14'd0;
      lbp_data_q  <= 8'd0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      nxt_q       <= nxt_d;
      cur_q       <= cur_d;
      gray_req_q  <= req_d;
      gray_addr_q <= addr_d;
      lbp_valid_q <= valid_d;
      lbp_addr_q  <= laddr_d;
      lbp_data_q  <= ldata_d;
      fin_q       <= fin_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) win_q[i] <= 8'd0;
    end else if (shift) begin
      for (int i = 0; i < 6; i++) win_q[i] <= win_q[i+3];
    end else if (gray_req_q) begin
      win_q[cur_q] <= gray_data;
    end
  end

endmodule

// File: tb/tb_lbp_core.sv
// Directed bench for lbp_core: reset values, ready gating, ramp image, mid-run reset,
// and a full spike-image run checked against a pixel-level LBP model.
module tb_lbp_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data = 8'h00;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic [2:0]  dbg_state;

  lbp_core dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

`ifdef LBP_BORDER_WRITE_EN
  localparam int EXP_WR = 16384, EXP_BORDER = 508, EXP_LAST = 16383, EXP_FIN_GAP = 1;
`else
  localparam int EXP_WR = 15876, EXP_BORDER = 0, EXP_LAST = 16254, EXP_FIN_GAP = 2;
`endif

  logic [7:0]  img [16384];
  logic [7:0]  res [16384];
  logic [13:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          wc_q [$];
  int tests = 0, fails = 0;
  int cyc = 0, overlap_cnt = 0;
  int wr_cnt, border_cnt, last_wr_cyc, last_wr_addr;

  always @(posedge clk) cyc++;

  // Image memory: answers a request registered at an edge by the following edge.
  always @(posedge clk) begin
    #1;
    if (gray_req) gray_data = img[gray_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (!reset) begin
      if (lbp_valid) begin
        wa_q.push_back(lbp_addr);
        wd_q.push_back(lbp_data);
        wc_q.push_back(cyc);
      end
      if (lbp_valid && gray_req) overlap_cnt++;
    end
  endtask

  task automatic get_write(output logic [13:0] a, output logic [7:0] d, output int c,
                           output bit ok);
    int n = 0;
    while (wa_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    ok = (wa_q.size() != 0);
    a = 14'd0; d = 8'd0; c = 0;
    if (ok) begin
      a = wa_q.pop_front();
      d = wd_q.pop_front();
      c = wc_q.pop_front();
    end
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!gray_req && n < 50) begin
      tick();
      n++;
    end
    ok = gray_req;
  endtask

  task automatic drain();
    while (wa_q.size() > 0) begin
      last_wr_addr = int'(wa_q.pop_front());
      res[last_wr_addr] = wd_q.pop_front();
      last_wr_cyc = wc_q.pop_front();
      wr_cnt++;
      if (last_wr_addr / 128 == 0 || last_wr_addr / 128 == 127 ||
          last_wr_addr % 128 == 0 || last_wr_addr % 128 == 127) border_cnt++;
    end
  endtask

  function automatic logic [7:0] lbp_model(input int r, input int c);
    logic [7:0] ctr;
    logic [7:0] v;
    ctr = img[r*128 + c];
    v[0] = img[(r-1)*128 + c-1] >= ctr;
    v[1] = img[(r-1)*128 + c]   >= ctr;
    v[2] = img[(r-1)*128 + c+1] >= ctr;
    v[3] = img[r*128 + c-1]     >= ctr;
    v[4] = img[r*128 + c+1]     >= ctr;
    v[5] = img[(r+1)*128 + c-1] >= ctr;
    v[6] = img[(r+1)*128 + c]   >= ctr;
    v[7] = img[(r+1)*128 + c+1] >= ctr;
    return v;
  endfunction

  initial begin
    logic [13:0] a;
    logic [7:0]  d;
    int          c, first_req_cyc, fin_cyc, bad, cnt, n, exp_addr;
    bit          ok;

    reset = 1'b1;
    gray_ready = 1'b0;
    for (int i = 0; i < 16384; i++) img[i] = 8'(i % 128);

    repeat (3) @(negedge clk);
    check("rst_gray_req", gray_req, 0);
    check("rst_gray_addr", gray_addr, 0);
    check("rst_lbp_valid", lbp_valid, 0);
    check("rst_lbp_addr", lbp_addr, 0);
    check("rst_lbp_data", lbp_data, 0);
    check("rst_finish", finish, 0);
    check("rst_state_idle", dbg_state, 0);

    // Memory not ready for 20 cycles after release.
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gray_req) cnt++;
    end
    check("ready_low_no_req", cnt, 0);
    check("ready_low_idle", dbg_state, 0);

    // Ramp image: first window timing and value.
    gray_ready = 1'b1;
    wait_req(ok);
    check("ramp_first_req_seen", ok, 1);
    check("ramp_first_addr", gray_addr, 0);
    first_req_cyc = cyc;
    get_write(a, d, c, ok);
    check("ramp_first_wr_seen", ok, 1);
    check("ramp_first_wr_addr", a, 129);
    check("ramp_first_wr_data", d, 214);
    check("ramp_first_wr_latency", c - first_req_cyc, 9);

    for (int i = 1; i < 10; i++) begin
      get_write(a, d, c, ok);
      check("ramp_seq_addr", a, 129 + i);
      check("ramp_seq_data", d, 214);
    end

    // Stall mid-row: no reads while ready is low, results unaffected afterwards.
    gray_ready = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gray_req) cnt++;
    end
    check("stall_no_req", cnt, 0);
    gray_ready = 1'b1;

    bad = 0;
    for (int i = 10; i < 130; i++) begin
      get_write(a, d, c, ok);
      exp_addr = (1 + i / 126) * 128 + (1 + i % 126);
      if (!ok || a != 14'(exp_addr) || d != 8'd214) bad++;
      if (i == 126) check("ramp_row2_start_addr", a, 257);
    end
    check("ramp_stream_bad", bad, 0);

    // Asynchronous reset in the middle of a fetch.
    wait_req(ok);
    check("midrun_req_seen", ok, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_gray_req", gray_req, 0);
    check("async_rst_gray_addr", gray_addr, 0);
    check("async_rst_lbp_valid", lbp_valid, 0);
    check("async_rst_lbp_addr", lbp_addr, 0);
    check("async_rst_lbp_data", lbp_data, 0);
    check("async_rst_state", dbg_state, 0);

    // Spike image: background 10, (64,64)=200.
    for (int i = 0; i < 16384; i++) begin
      img[i] = 8'd10;
      res[i] = 8'h55;
    end
    img[8256] = 8'd200;
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    wr_cnt = 0;
    border_cnt = 0;
    last_wr_cyc = 0;
    last_wr_addr = 0;
    overlap_cnt = 0;
    tick();
    reset = 1'b0;
    wait_req(ok);
    check("restart_req_seen", ok, 1);
    check("restart_first_addr", gray_addr, 0);

    n = 0;
    while (!finish && n < 70000) begin
      tick();
      drain();
      n++;
    end
    fin_cyc = cyc;
    check("finish_seen", finish, 1);
    drain();
    check("write_count", wr_cnt, EXP_WR);
    check("border_writes", border_cnt, EXP_BORDER);
    check("last_write_addr", last_wr_addr, EXP_LAST);
    check("finish_gap", fin_cyc - last_wr_cyc, EXP_FIN_GAP);
    check("spike_centre_8256", res[8256], 0);
    check("spike_left_8255", res[8255], 255);
    check("flat_first_129", res[129], 255);
    check("flat_last_16254", res[16254], 255);

    bad = 0;
    for (int r = 1; r < 127; r++)
      for (int cc = 1; cc < 127; cc++)
        if (res[r*128 + cc] !== lbp_model(r, cc)) bad++;
    check("interior_vs_model", bad, 0);
`ifdef LBP_BORDER_WRITE_EN
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (res[i] !== 8'd0 || res[127*128 + i] !== 8'd0 ||
          res[i*128] !== 8'd0 || res[i*128 + 127] !== 8'd0) bad++;
    check("border_zero", bad, 0);
`endif

    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gray_req || lbp_valid || !finish) cnt++;
    end
    drain();
    check("done_quiet_finish_held", cnt, 0);
    check("done_state", dbg_state, 4);
    check("no_valid_req_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lbp_core.md
LBP_CORE -- requirements
Module: lbp_core

Interface
REQ-001 The block SHALL have no parameters; the image is fixed at 128x128 8-bit pixels, raster address = row*128 + col.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 gray_ready  input  1  image memory available; no fetch SHALL start while low.
REQ-005 gray_req  output  1  read request for the pixel at gray_addr.
REQ-006 gray_addr  output  14  read address.
REQ-007 gray_data  input  8  read data, valid at the rising edge one cycle after the edge that registered gray_req=1.
REQ-008 lbp_valid  output  1  write strobe, one cycle per result.
REQ-009 lbp_addr  output  14  result address (centre-pixel address).
REQ-010 lbp_data  output  8  LBP result.
REQ-011 finish  output  1  all results written; held high until reset.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 States: IDLE (wait gray_ready=1), FETCH (issue reads), CALC (one cycle, write result), DONE (finish=1, no further requests or writes).
REQ-014 Interior centres (row, col in 1..126) SHALL be processed row-major, left to right, top to bottom.
REQ-015 Window fetch order is column-major: col-1, col, col+1; within each column, rows row-1, row, row+1.
REQ-016 At col=1 all 9 pixels SHALL be fetched; for col>1 only column col+1 (3 reads), the two older columns being shifted in the window registers.
REQ-017 One read SHALL issue per cycle while in FETCH; gray_req SHALL be low in IDLE, CALC and DONE.
REQ-018 lbp_data bit = 1 when neighbour >= centre (unsigned 8-bit); bit0 top-left, bit1 top, bit2 top-right, bit3 left, bit4 right, bit5 bottom-left, bit6 bottom, bit7 bottom-right.
REQ-019 CALC SHALL assert lbp_valid for exactly one cycle, with lbp_addr = row*128+col, one cycle after the last read data of the window is captured.
REQ-020 After centre (126,126) is written, the block SHALL enter DONE and assert finish on the following cycle.
REQ-021 gray_ready falling mid-operation SHALL stall: no new reads issue until it returns high; captured window data is kept.
REQ-022 lbp_valid and gray_req SHALL never be high in the same cycle.

Reset
REQ-023 Reset SHALL force gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0 and state IDLE, at any time including mid-fetch or DONE.
REQ-024 After reset release, processing SHALL restart from centre (1,1) with a full 9-pixel fetch; no partial window SHALL be reused.

Configuration
REQ-025 Macro LBP_BORDER_WRITE_EN defined: before entering DONE the block SHALL write lbp_data=0 to every border address (row or col 0 or 127, 508 writes), one per cycle, with no reads; 16384 writes in total.
REQ-026 Macro undefined: lbp_valid SHALL never be asserted for a border address; 15876 writes in total.

Verification
REQ-027 All pixels 50 -> every interior result 255, border 0, finish asserted, gray_req low thereafter.
REQ-028 Pixel value = col (horizontal ramp) -> every interior result 214 (0xD6).
REQ-029 Background 10, pixel (64,64)=200 -> lbp at address 8256 = 0; address 8255 (right neighbour is 200) = 255.
REQ-030 gray_ready held low 20 cycles after reset -> gray_req stays 0 for those cycles; first read at address 0, first write lbp_addr=129 after 9 reads + 1 cycle.
REQ-031 Reset pulsed at cycle 5000 -> all outputs 0 within the reset cycle; next read address 0; final memory matches golden image.
REQ-032 Count lbp_valid pulses -> 16384 with LBP_BORDER_WRITE_EN, 15876 without; none occur in the same cycle as gray_req.
